// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the video timing / test-pattern source:
//   - counter width used for h_cnt / v_cnt / x / y
//   - standard 1080p60 and 720p60 timing constants
//   - pattern_e enum selecting the runtime test pattern
//   - 8-entry colour-bar table (3-bit {r,g,b} on/off per bar) and lookup
// No ports (package).
// ---------------------------------------------------------------------------
package video_timing_pkg;

  localparam int CNT_W = 12;

  // 1080p60 (148.5 MHz pixel clock)
  localparam int T1080_H_ACTIVE = 1920;
  localparam int T1080_H_FP     = 88;
  localparam int T1080_H_SYNC   = 44;
  localparam int T1080_H_BP     = 148;
  localparam int T1080_V_ACTIVE = 1080;
  localparam int T1080_V_FP     = 4;
  localparam int T1080_V_SYNC   = 5;
  localparam int T1080_V_BP     = 36;

  // 720p60 (74.25 MHz pixel clock)
  localparam int T720_H_ACTIVE = 1280;
  localparam int T720_H_FP     = 110;
  localparam int T720_H_SYNC   = 40;
  localparam int T720_H_BP     = 220;
  localparam int T720_V_ACTIVE = 720;
  localparam int T720_V_FP     = 5;
  localparam int T720_V_SYNC   = 5;
  localparam int T720_V_BP     = 20;

  typedef enum logic [1:0] {
    BARS  = 2'd0,
    GRID  = 2'd1,
    GRAD  = 2'd2,
    SOLID = 2'd3
  } pattern_e;

  // Bar k occupies bits [3k+2:3k] as {r,g,b}. Order left to right:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_TABLE = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    bar_rgb = BAR_TABLE[int'(idx) * 3 +: 3];
  endfunction

endpackage

// File: rtl/video_sync_cnt.sv
// ---------------------------------------------------------------------------
// video_sync_cnt
// Horizontal / vertical position counters and their combinational decode.
// Active region comes first on each line and each frame, followed by
// front porch, sync and back porch.
// Ports:
//   pixclk          pixel clock
//   rstn            asynchronous active-low reset
//   en              run enable; low forces both counters to 0 next clock
//   h_cnt_o/v_cnt_o current counter values
//   active_o        counters lie inside the active picture
//   hs_on_o/vs_on_o sync interval (polarity not applied)
//   frame_first_o   counters at (0,0)
//   line_last_o     h_cnt at its last value (line wraps next clock)
// ---------------------------------------------------------------------------
module video_sync_cnt
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic             pixclk,
  input  logic             rstn,
  input  logic             en,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             active_o,
  output logic             hs_on_o,
  output logic             vs_on_o,
  output logic             frame_first_o,
  output logic             line_last_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode thresholds held as 32-bit values so an end point equal to 4096
  // still compares correctly against the 12-bit counters.
  localparam logic [31:0] H_ACT_C  = 32'(H_ACTIVE);
  localparam logic [31:0] H_HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] H_HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_ACT_C  = 32'(V_ACTIVE);
  localparam logic [31:0] V_VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] V_VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);

  if (H_TOTAL > 4096) begin : g_bad_h_total
    $error("video_sync_cnt: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 4096) begin : g_bad_v_total
    $error("video_sync_cnt: V_TOTAL exceeds 4096");
  end

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [31:0]      h_ext, v_ext;

  assign h_ext = {{(32 - CNT_W){1'b0}}, h_cnt_q};
  assign v_ext = {{(32 - CNT_W){1'b0}}, v_cnt_q};

  // Counter next-state: zero while disabled, otherwise raster scan with wrap.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_ext == H_LAST) begin
      h_cnt_d = '0;
      if (v_ext == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 12'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 12'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge pixclk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign active_o      = (h_ext < H_ACT_C) && (v_ext < V_ACT_C);
  assign hs_on_o       = (h_ext >= H_HS_BEG) && (h_ext < H_HS_END);
  // Depends on v_cnt only, so vs moves together with the h wrap.
  assign vs_on_o       = (v_ext >= V_VS_BEG) && (v_ext < V_VS_END);
  assign frame_first_o = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
  assign line_last_o   = (h_ext == H_LAST);

endmodule

// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
// Parametrised video timing and test-pattern source. One clock of latency:
// outputs at cycle n describe the counter position of cycle n-1.
// Ports:
//   pixclk       pixel clock (only clock)
//   rstn         asynchronous active-low reset
//   en           run enable; low blanks outputs and parks counters at (0,0)
//   pattern_sel  0 bars, 1 grid, 2 gradient, 3 solid; taken at frame start
//   solid_rgb    {r,g,b} for the solid pattern, used live
//   vs/hs/de     registered syncs (POL-adjusted) and data enable
//   r_out/g_out/b_out  pixel colour, 0 in blanking
//   x/y          active pixel coordinate, 0 in blanking
//   frame_start  one-cycle pulse with pixel (0,0)
// ---------------------------------------------------------------------------
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 1920,
  parameter int H_FP      = 88,
  parameter int H_SYNC    = 44,
  parameter int H_BP      = 148,
  parameter int V_ACTIVE  = 1080,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 36,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int COLOR_W   = 8,
  parameter int GRID_LOG2 = 6
) (
  input  logic                 pixclk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [1:0]           pattern_sel,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic                 vs,
  output logic                 hs,
  output logic                 de,
  output logic [COLOR_W-1:0]   r_out,
  output logic [COLOR_W-1:0]   g_out,
  output logic [COLOR_W-1:0]   b_out,
  output logic [11:0]          x,
  output logic [11:0]          y,
  output logic                 frame_start
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [31:0] BAR_LAST = 32'(BAR_W - 1);
  localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};

  if ((H_ACTIVE % 8) != 0 || H_ACTIVE < 8) begin : g_bad_h_active
    $error("video_pattern_gen: H_ACTIVE must be a non-zero multiple of 8");
  end
  if (GRID_LOG2 < 1 || GRID_LOG2 > 11) begin : g_bad_grid
    $error("video_pattern_gen: GRID_LOG2 out of range");
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active, hs_on, vs_on, frame_first, line_last;

  video_sync_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync_cnt (
    .pixclk        (pixclk),
    .rstn          (rstn),
    .en            (en),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .active_o      (active),
    .hs_on_o       (hs_on),
    .vs_on_o       (vs_on),
    .frame_first_o (frame_first),
    .line_last_o   (line_last)
  );

  // -------------------------------------------------------------------------
  // Pattern register. The selection is sampled at (0,0) and also applied to
  // pixel (0,0) itself, so a whole frame always uses a single pattern.
  // -------------------------------------------------------------------------
  pattern_e pattern_q, pattern_d;
  pattern_e pat_eff;

  // Effective pattern for the pixel now being decoded.
  always_comb begin
    if (frame_first && en) begin
      pat_eff = pattern_e'(pattern_sel);
    end else begin
      pat_eff = pattern_q;
    end
    pattern_d = pat_eff;
  end

  // Pattern register.
  always_ff @(posedge pixclk or negedge rstn) begin
    if (!rstn) begin
      pattern_q <= BARS;
    end else begin
      pattern_q <= pattern_d;
    end
  end

  // -------------------------------------------------------------------------
  // Bar counter: tracks the bar index of the current h_cnt without a divide.
  // bar_pos_q counts pixels inside the bar; the index steps when it wraps.
  // Both park at 0 whenever h_cnt does (line wrap or disabled).
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] bar_pos_q, bar_pos_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [31:0]      bar_pos_ext;

  assign bar_pos_ext = {{(32 - CNT_W){1'b0}}, bar_pos_q};

  // Bar counter next-state.
  always_comb begin
    bar_pos_d = bar_pos_q;
    bar_idx_d = bar_idx_q;
    if (!en || line_last) begin
      bar_pos_d = '0;
      bar_idx_d = 3'd0;
    end else if (bar_pos_ext == BAR_LAST) begin
      bar_pos_d = '0;
      bar_idx_d = bar_idx_q + 3'd1;
    end else begin
      bar_pos_d = bar_pos_q + 12'd1;
    end
  end

  // Bar counter registers.
  always_ff @(posedge pixclk or negedge rstn) begin
    if (!rstn) begin
      bar_pos_q <= '0;
      bar_idx_q <= 3'd0;
    end else begin
      bar_pos_q <= bar_pos_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // -------------------------------------------------------------------------
  // Colour mux.
  // -------------------------------------------------------------------------
  logic [2:0]         bar_on;
  logic               grid_on;
  logic [COLOR_W-1:0] grad_val;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

  assign bar_on   = bar_rgb(bar_idx_q);
  assign grid_on  = (h_cnt[GRID_LOG2-1:0] == '0) || (v_cnt[GRID_LOG2-1:0] == '0);
  assign grad_val = COLOR_W'(h_cnt);

  // Pixel colour for the current position under the effective pattern.
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (pat_eff)
      BARS: begin
        pix_r = bar_on[2] ? FULL : '0;
        pix_g = bar_on[1] ? FULL : '0;
        pix_b = bar_on[0] ? FULL : '0;
      end
      GRID: begin
        pix_r = grid_on ? FULL : '0;
        pix_g = grid_on ? FULL : '0;
        pix_b = grid_on ? FULL : '0;
      end
      GRAD: begin
        pix_r = grad_val;
        pix_g = grad_val;
        pix_b = grad_val;
      end
      SOLID: begin
        pix_r = solid_rgb[3*COLOR_W-1:2*COLOR_W];
        pix_g = solid_rgb[2*COLOR_W-1:COLOR_W];
        pix_b = solid_rgb[COLOR_W-1:0];
      end
      default: begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output registers. Disabled means fully blank immediately, independent of
  // where the counters stand.
  // -------------------------------------------------------------------------
  logic               vs_q, vs_d, hs_q, hs_d, de_q, de_d, fs_q, fs_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [11:0]        x_q, x_d, y_q, y_d;

  // Output next-state: blank defaults, then the decoded pixel when running.
  always_comb begin
    vs_d = ~VS_POL;
    hs_d = ~HS_POL;
    de_d = 1'b0;
    fs_d = 1'b0;
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    x_d  = 12'd0;
    y_d  = 12'd0;
    if (en) begin
      vs_d = vs_on ? VS_POL : ~VS_POL;
      hs_d = hs_on ? HS_POL : ~HS_POL;
      de_d = active;
      fs_d = frame_first;
      if (active) begin
        r_d = pix_r;
        g_d = pix_g;
        b_d = pix_b;
        x_d = h_cnt;
        y_d = v_cnt;
      end else begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
      end
    end else begin
      de_d = 1'b0;
    end
  end

  // Output register bank.
  always_ff @(posedge pixclk or negedge rstn) begin
    if (!rstn) begin
      vs_q <= ~VS_POL;
      hs_q <= ~HS_POL;
      de_q <= 1'b0;
      fs_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      x_q  <= 12'd0;
      y_q  <= 12'd0;
    end else begin
      vs_q <= vs_d;
      hs_q <= hs_d;
      de_q <= de_d;
      fs_q <= fs_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign vs          = vs_q;
  assign hs          = hs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign r_out       = r_q;
  assign g_out       = g_q;
  assign b_out       = b_q;
  assign x           = x_q;
  assign y           = y_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_video_pattern_gen
// Small-timing bench: 16+2+3+3 pixels per line, 8+1+2+1 lines per frame.
// A position-based model predicts every output each clock; directed literal
// checks pin the model at hand-computed points.
// ---------------------------------------------------------------------------
module tb_video_pattern_gen;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSY = 3;
  localparam int HBP = 3;
  localparam int VA  = 8;
  localparam int VFP = 1;
  localparam int VSY = 2;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HSY + HBP;  // 24
  localparam int VT  = VA + VFP + VSY + VBP;  // 12
  localparam int FT  = HT * VT;               // 288

  logic        pixclk = 1'b0;
  logic        rstn;
  logic        en;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic        vs, hs, de, frame_start;
  logic [7:0]  r_out, g_out, b_out;
  logic [11:0] x, y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // output cycle index since reset release
  int pos   = 0;   // model: raster position the DUT will output next
  int fpat  = 0;   // model: pattern latched for the current frame
  int vs_hi = 0;
  logic [51:0] exp_v, act_v;

  video_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
    .HS_POL (1'b1), .VS_POL (1'b1), .COLOR_W (8), .GRID_LOG2 (2)
  ) dut (
    .pixclk      (pixclk),
    .rstn        (rstn),
    .en          (en),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .vs          (vs),
    .hs          (hs),
    .de          (de),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .x           (x),
    .y           (y),
    .frame_start (frame_start)
  );

  always #5 pixclk = ~pixclk;

  // Expected {vs,hs,de,r,g,b,x,y,frame_start} for raster position p.
  function automatic logic [51:0] model(input int p, input int pat, input logic [23:0] solid);
    int h, v, bar;
    logic a, hs_e, vs_e;
    logic [7:0] r, g, b;
    h = p % HT;
    v = p / HT;
    a = (h < HA) && (v < VA);
    hs_e = (h >= HA + HFP) && (h < HA + HFP + HSY);
    vs_e = (v >= VA + VFP) && (v < VA + VFP + VSY);
    r = 8'h00; g = 8'h00; b = 8'h00;
    if (a) begin
      case (pat)
        0: begin
          bar = h / (HA / 8);
          r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 8'hFF : 8'h00;
          g = (bar <= 3) ? 8'hFF : 8'h00;
          b = (bar % 2 == 0) ? 8'hFF : 8'h00;
        end
        1: if (h % 4 == 0 || v % 4 == 0) begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
        2: begin r = 8'(h); g = 8'(h); b = 8'(h); end
        default: begin r = solid[23:16]; g = solid[15:8]; b = solid[7:0]; end
      endcase
    end
    model = {vs_e, hs_e, a, r, g, b, a ? 12'(h) : 12'd0, a ? 12'(v) : 12'd0, (p == 0)};
  endfunction

  // Model update on each edge and comparison just after it.
  always @(posedge pixclk) begin
    if (!rstn) begin
      exp_v = 52'd0;
      pos   = 0;
      fpat  = 0;
      cyc   = 0;
    end else begin
      cyc++;
      if (!en) begin
        exp_v = 52'd0;
        pos   = 0;
      end else begin
        if (pos == 0) fpat = int'(pattern_sel);
        exp_v = model(pos, fpat, solid_rgb);
        pos   = (pos + 1) % FT;
      end
    end
    #1;
    act_v = {vs, hs, de, r_out, g_out, b_out, x, y, frame_start};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL model cyc=%0d got=%h want=%h (vs hs de rgb x y fs)", cyc, act_v, exp_v);
    end
    if (vs) vs_hi++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < k) @(negedge pixclk);
  endtask

  initial begin
    rstn        = 1'b0;
    en          = 1'b1;
    pattern_sel = 2'd0;
    solid_rgb   = 24'h000000;
    repeat (3) @(negedge pixclk);
    chk("reset_sync_de", {29'd0, vs, hs, de}, 32'd0);
    chk("reset_rgb", {8'd0, r_out, g_out, b_out}, 32'd0);
    chk("reset_xy_fs", {7'd0, x, y, frame_start}, 32'd0);

    rstn = 1'b1;
    goto(1);
    chk("start_fs_de", {30'd0, frame_start, de}, 32'd3);
    chk("bar_x0", {8'd0, r_out, g_out, b_out}, 32'hFFFFFF);
    goto(2);  chk("fs_one_cycle", {31'd0, frame_start}, 32'd0);
    goto(3);  chk("bar_x2", {8'd0, r_out, g_out, b_out}, 32'hFFFF00);
    goto(11); chk("bar_x10", {8'd0, r_out, g_out, b_out}, 32'hFF0000);
    goto(16); chk("bar_x15", {7'd0, de, r_out, g_out, b_out}, 32'h1000000);
    goto(17); chk("blank_de_rgb", {7'd0, de, r_out, g_out, b_out}, 32'd0);
    goto(18); chk("hs_before", {31'd0, hs}, 32'd0);
    goto(19); chk("hs_first", {31'd0, hs}, 32'd1);
    goto(21); chk("hs_last", {31'd0, hs}, 32'd1);
    goto(22); chk("hs_after", {31'd0, hs}, 32'd0);
    goto(25); chk("line1_start", {19'd0, de, x, y[11:0] == 12'd1}, {19'd0, 1'b1, 12'd0, 1'b1});

    // Mode switch mid-frame: must not affect the current frame.
    goto(73);
    pattern_sel = 2'd3;
    solid_rgb   = 24'h123456;
    goto(100); chk("switch_deferred", {8'd0, r_out, g_out, b_out}, 32'hFFFF00);
    goto(216); chk("vs_before", {31'd0, vs}, 32'd0);
    goto(217); chk("vs_line9", {31'd0, vs}, 32'd1);
    goto(264); chk("vs_last", {31'd0, vs}, 32'd1);
    goto(265); chk("vs_after", {31'd0, vs}, 32'd0);
    goto(288); chk("fs_not_early", {31'd0, frame_start}, 32'd0);
    chk("vs_high_count", 32'(vs_hi), 32'd48);
    goto(289); chk("frame2_fs", {31'd0, frame_start}, 32'd1);
    chk("frame2_solid0", {8'd0, r_out, g_out, b_out}, 32'h123456);
    pattern_sel = 2'd1;
    goto(416); chk("frame2_solid", {8'd0, r_out, g_out, b_out}, 32'h123456);

    // Grid frame (starts at 577).
    goto(605); chk("grid_x4_y1", {8'd0, r_out, g_out, b_out}, 32'hFFFFFF);
    goto(606); chk("grid_x5_y1", {8'd0, r_out, g_out, b_out}, 32'h000000);
    goto(678); chk("grid_x5_y4", {8'd0, r_out, g_out, b_out}, 32'hFFFFFF);
    pattern_sel = 2'd2;

    // Gradient frame (starts at 865).
    goto(920);  chk("grad_x7", {8'd0, r_out, g_out, b_out}, 32'h070707);
    goto(1000); chk("grad_x15", {8'd0, r_out, g_out, b_out}, 32'h0F0F0F);
    goto(1153); chk("frame5_fs", {31'd0, frame_start}, 32'd1);

    // Enable abort with counters at h=5, v=3.
    goto(1229);
    en = 1'b0;
    goto(1231);
    chk("abort_blank", {5'd0, vs, hs, de, r_out, g_out, b_out}, 32'd0);
    chk("abort_xy", {8'd0, x, y}, 32'd0);
    goto(1235);
    en = 1'b1;
    goto(1236);
    chk("restart_fs_de", {30'd0, frame_start, de}, 32'd3);
    chk("restart_y", {20'd0, y}, 32'd0);

    // Asynchronous reset mid-line.
    goto(1240);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset", {5'd0, vs, hs, de, r_out, g_out, b_out}, 32'd0);
    chk("async_reset_xy", {7'd0, x, y, frame_start}, 32'd0);
    repeat (2) @(negedge pixclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
